// File: rtl/command_fifo.sv
// Buffers command words from the decoder and replays them as single-cycle pulses spaced by GAP_CYCLES.
// Latency: a word written to an empty FIFO pulses two cycles after its write strobe. Overflow is a sticky drop flag.
// Backpressure: i_hold stalls pops. Optional CMD_FIFO_SYNC_RELEASE_EN gates release to budgets loaded on i_sync.
module command_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  i_command_clk,
    input  logic                  i_reset,
    input  logic                  i_command,
    input  logic [WIDTH-1:0]      i_command_data,
    input  logic                  i_hold,
    input  logic                  i_overflow_clear,
    input  logic                  i_sync,
    output logic                  o_command,
    output logic [WIDTH-1:0]      o_command_data,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [GAP_W-1:0]      GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_ONE   = GAP_W'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  release_ok;

`ifdef CMD_FIFO_SYNC_RELEASE_EN
    logic [DEPTH_LOG2:0] budget;

    // Budget snapshots the post-edge level so a word written alongside i_sync joins this batch.
    always_ff @(posedge i_command_clk) begin
        if (i_reset) begin
            budget <= '0;
        end else if (i_sync) begin
            budget <= level_nxt;
        end else if (pop) begin
            budget <= budget - LEVEL_ONE;
        end
    end

    assign release_ok = (budget != '0);
`else
    logic unused_sync;
    assign unused_sync = i_sync;
    assign release_ok  = 1'b1;
`endif

    // Pop decisions use the registered level, so a write into an empty FIFO cannot pop the same cycle.
    always_comb begin
        pop       = (o_level != '0) && !i_hold && (gap_cnt == '0) && release_ok;
        push      = i_command && (!o_full || pop);
        drop      = i_command && o_full && !pop;
        level_nxt = o_level;
        if (push && !pop) begin
            level_nxt = o_level + LEVEL_ONE;
        end else if (pop && !push) begin
            level_nxt = o_level - LEVEL_ONE;
        end
    end

    always_ff @(posedge i_command_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_command_data;
        end
    end

    always_ff @(posedge i_command_clk) begin
        if (i_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            gap_cnt        <= '0;
            o_level        <= '0;
            o_empty        <= 1'b1;
            o_full         <= 1'b0;
            o_command      <= 1'b0;
            o_command_data <= '0;
            o_overflow     <= 1'b0;
        end else begin
            o_level   <= level_nxt;
            o_empty   <= (level_nxt == '0);
            o_full    <= (level_nxt == LEVEL_MAX);
            o_command <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                o_command_data <= mem[rd_ptr];
                rd_ptr         <= rd_ptr + PTR_ONE;
                gap_cnt        <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_overflow_clear) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule
